match_run_detector: RTL and testbench

- Sequential stage directly downstream of the N-bit equality compare path: accepts a stream of operand pairs (x, y), evaluates equality per accepted pair, tracks consecutive-match runs and total mismatches.
- Asserts a lock indication once RUN_LEN consecutive equal pairs are seen.
- Used as the qualification stage feeding status/control logic that needs a stable "operands agree" condition rather than a single-cycle compare.

---
 rtl/match_run_detector_pkg.sv | 14 +
 rtl/match_run_detector_eq_compare_core.sv | 12 +
 rtl/match_run_detector.sv | 91 +++++++++
 tb/tb_match_run_detector.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/match_run_detector_pkg.sv
// Shared types and helpers for the match-run qualification stage.
package match_run_detector_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // All-ones value of a w-bit saturating counter.
  function automatic longint unsigned cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/match_run_detector_eq_compare_core.sv
// Combinational N-bit equality: AND-reduction of bitwise XNOR.
module eq_compare_core #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq_c
);

  assign eq_c = &(a ~^ b);

endmodule

// File: rtl/match_run_detector.sv
// Tracks consecutive equal operand pairs and locks after RUN_LEN in a row.
module match_run_detector
  import match_run_detector_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     y,
  output logic             eq_q,
  output logic             eq_valid,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             locked,
  output logic             detect
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] RUN_TGT = CNT_W'(RUN_LEN);

  logic             eq_c;
  state_t           state_q, state_d;
  logic             eq_q_d, eq_valid_d, locked_d, detect_d;
  logic [CNT_W-1:0] run_d, mis_d, run_inc, mis_inc;

  eq_compare_core #(.N(N)) u_eq (
    .a    (x),
    .b    (y),
    .eq_c (eq_c)
  );

  assign run_inc = (run_count == CNT_MAX) ? run_count : run_count + CNT_W'(1);
  assign mis_inc = (mismatch_count == CNT_MAX) ? mismatch_count : mismatch_count + CNT_W'(1);

  // Next-state and next-output decode; clear outranks an accepted pair.
  always_comb begin
    state_d    = state_q;
    eq_q_d     = eq_q;
    eq_valid_d = 1'b0;
    detect_d   = 1'b0;
    run_d      = run_count;
    mis_d      = mismatch_count;
    if (clear) begin
      state_d = SEARCH;
      eq_q_d  = 1'b0;
      run_d   = '0;
      mis_d   = '0;
    end else if (in_valid) begin
      eq_valid_d = 1'b1;
      eq_q_d     = eq_c;
      if (eq_c) begin
        run_d = run_inc;
        if (state_q == SEARCH && run_inc == RUN_TGT) begin
          state_d  = LOCKED;
          detect_d = 1'b1;
        end
      end else begin
        state_d = SEARCH;
        run_d   = '0;
        mis_d   = mis_inc;
      end
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q        <= SEARCH;
      eq_q           <= 1'b0;
      eq_valid       <= 1'b0;
      run_count      <= '0;
      mismatch_count <= '0;
      locked         <= 1'b0;
      detect         <= 1'b0;
    end else begin
      state_q        <= state_d;
      eq_q           <= eq_q_d;
      eq_valid       <= eq_valid_d;
      run_count      <= run_d;
      mismatch_count <= mis_d;
      locked         <= locked_d;
      detect         <= detect_d;
    end
  end

endmodule

// File: tb/tb_match_run_detector.sv
// Randomized self-checking bench for match_run_detector against a counting model.
module tb_match_run_detector;

  localparam int N       = 3;
  localparam int RUN_LEN = 4;
  localparam int CNT_W   = 8;
  localparam int MAXV    = 255;

  logic             clock = 1'b0;
  logic             n_reset;
  logic             clear;
  logic             in_valid;
  logic [N-1:0]     x, y;
  logic             eq_q, eq_valid, locked, detect;
  logic [CNT_W-1:0] run_count, mismatch_count;

  int n_checks = 0;
  int n_fail   = 0;

  int m_run, m_mis;
  bit m_lock, m_eqq, m_eqv, m_det;

  match_run_detector #(.N(N), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .n_reset        (n_reset),
    .clear          (clear),
    .in_valid       (in_valid),
    .x              (x),
    .y              (y),
    .eq_q           (eq_q),
    .eq_valid       (eq_valid),
    .run_count      (run_count),
    .mismatch_count (mismatch_count),
    .locked         (locked),
    .detect         (detect)
  );

  always #5 clock = ~clock;

  function automatic logic [19:0] act_vec();
    return {eq_q, eq_valid, run_count, mismatch_count, locked, detect};
  endfunction

  function automatic logic [19:0] exp_vec();
    return {m_eqq, m_eqv, 8'(m_run), 8'(m_mis), m_lock, m_det};
  endfunction

  task automatic model_reset();
    m_run = 0; m_mis = 0; m_lock = 0; m_eqq = 0; m_eqv = 0; m_det = 0;
  endtask

  // Drive one cycle from a negedge, update the model at the edge, return at next negedge.
  task automatic step(input bit v, input bit c, input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = v; clear = c; x = a; y = b;
    @(posedge clock);
    if (c) begin
      model_reset();
    end else if (v) begin
      m_eqv = 1;
      m_eqq = (a == b);
      if (a == b) begin
        m_run = (m_run + 1 > MAXV) ? MAXV : m_run + 1;
        m_det = !m_lock && (m_run == RUN_LEN);
        if (m_run >= RUN_LEN) m_lock = 1;
      end else begin
        m_run  = 0;
        m_mis  = (m_mis + 1 > MAXV) ? MAXV : m_mis + 1;
        m_lock = 0;
        m_det  = 0;
      end
    end else begin
      m_eqv = 0;
      m_det = 0;
    end
    @(negedge clock);
    in_valid = 0; clear = 0;
  endtask

  task automatic test_reset();
    n_reset = 0; clear = 0; in_valid = 0; x = '0; y = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if (act_vec() !== 20'h0) begin
        n_fail++; $display("FAIL reset_hold: got %h want 00000", act_vec());
      end
    end
    n_reset = 1;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 3'($urandom), 3'($urandom));
      n_checks++;
      if (act_vec() !== 20'h0) begin
        n_fail++; $display("FAIL reset_idle: got %h want 00000", act_vec());
      end
    end
  endtask

  task automatic test_lock();
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 3'b101, 3'b101);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL lock_seq[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
      n_checks++;
      if ({run_count, detect, locked} !== {8'(i), i == 4, i >= 4}) begin
        n_fail++; $display("FAIL lock_fixed[%0d]: run=%0d det=%b lk=%b want run=%0d det=%b lk=%b",
                           i, run_count, detect, locked, i, i == 4, i >= 4);
      end
    end
  endtask

  task automatic test_break();
    step(0, 1, '0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 3'b101, 3'b101);
    step(1, 0, 3'b101, 3'b100);
    n_checks++;
    if ({run_count, mismatch_count, eq_q, locked} !== {8'd0, 8'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL break_run: run=%0d mis=%0d eq=%b lk=%b want 0 1 0 0",
                         run_count, mismatch_count, eq_q, locked);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 3'b011, 3'b011);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL break_relock[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (!(locked === 1'b1 && detect === 1'b1)) begin
      n_fail++; $display("FAIL break_lock_edge: lk=%b det=%b want 1 1", locked, detect);
    end
  endtask

  task automatic test_gaps();
    int valid_seen = 0;
    step(0, 1, '0, '0);
    while (valid_seen < 6) begin
      int gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        step(0, 0, 3'($urandom), 3'($urandom));
        n_checks++;
        if (act_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL gap_idle: got %h want %h", act_vec(), exp_vec());
        end
      end
      step(1, 0, 3'b110, 3'b110);
      valid_seen++;
      n_checks++;
      if (act_vec() !== exp_vec() || detect !== (valid_seen == 4)) begin
        n_fail++; $display("FAIL gap_valid[%0d]: got %h want %h", valid_seen, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_unlock_clear();
    step(1, 0, 3'b001, 3'b011);
    n_checks++;
    if ({locked, run_count, detect} !== {1'b0, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL unlock: lk=%b run=%0d det=%b want 0 0 0", locked, run_count, detect);
    end
    step(1, 1, 3'b111, 3'b111);
    n_checks++;
    if (act_vec() !== 20'h0) begin
      n_fail++; $display("FAIL clear_with_valid: got %h want 00000", act_vec());
    end
  endtask

  task automatic test_saturation();
    step(0, 1, '0, '0);
    for (int i = 0; i < 260; i++) step(1, 0, 3'b000, 3'b111);
    n_checks++;
    if (mismatch_count !== 8'd255) begin
      n_fail++; $display("FAIL sat_mismatch: got %0d want 255", mismatch_count);
    end
    for (int i = 0; i < 260; i++) step(1, 0, 3'b010, 3'b010);
    n_checks++;
    if ({run_count, locked, detect} !== {8'd255, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sat_run: run=%0d lk=%b det=%b want 255 1 0", run_count, locked, detect);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] a = 3'($urandom);
      logic [N-1:0] b = ($urandom_range(0, 3) != 0) ? a : 3'($urandom);
      step($urandom_range(0, 4) != 0, $urandom_range(0, 40) == 0, a, b);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    step(0, 1, '0, '0);
    for (int i = 0; i < 5; i++) step(1, 0, 3'b100, 3'b100);
    #2 n_reset = 0;
    #1;
    n_checks++;
    if (act_vec() !== 20'h0) begin
      n_fail++; $display("FAIL async_reset: got %h want 00000", act_vec());
    end
    model_reset();
    @(negedge clock);
    n_reset = 1;
    step(1, 0, 3'b100, 3'b100);
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL after_reset: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_break();
    test_gaps();
    test_unlock_clear();
    test_saturation();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
